// File: rtl/hazard_fwd_unit.sv
// Forwarding-select, load-use stall and branch-flush control for the 5-stage core.
// Tracks register usage in its own EX/MEM/WB shadow slots, fed from ID decode fields.
module hazard_fwd_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              ex_v, ex_use1, ex_use2, ex_we, ex_ld;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              mem_v, mem_we, mem_ld;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_v, wb_we;
  logic [REG_AW-1:0] wb_rd;

  logic ex_wr, mem_wr, wb_wr, mem_alu_wr;

  always_comb begin
    ex_wr      = ex_v  & ex_we  & (ex_rd  != '0);
    mem_wr     = mem_v & mem_we & (mem_rd != '0);
    wb_wr      = wb_v  & wb_we  & (wb_rd  != '0);
    mem_alu_wr = mem_wr & ~mem_ld;
    flush      = br_taken;
    // A redirect squashes the consumer anyway, so it never stalls.
    stall      = ~br_taken & id_valid & ex_ld & ex_wr &
                 ((id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd)));
  end

  always_comb begin
    fwd_a = 2'b00;
    if (ex_v && ex_use1) begin
      if (mem_alu_wr && (mem_rd == ex_rs1))  fwd_a = 2'b10;
      else if (wb_wr && (wb_rd == ex_rs1))   fwd_a = 2'b01;
    end
  end

  always_comb begin
    fwd_b = 2'b00;
    if (ex_v && ex_use2) begin
      if (mem_alu_wr && (mem_rd == ex_rs2))  fwd_b = 2'b10;
      else if (wb_wr && (wb_rd == ex_rs2))   fwd_b = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_v    <= 1'b0;
      ex_rs1  <= '0;
      ex_rs2  <= '0;
      ex_use1 <= 1'b0;
      ex_use2 <= 1'b0;
      ex_rd   <= '0;
      ex_we   <= 1'b0;
      ex_ld   <= 1'b0;
      mem_v   <= 1'b0;
      mem_rd  <= '0;
      mem_we  <= 1'b0;
      mem_ld  <= 1'b0;
      wb_v    <= 1'b0;
      wb_rd   <= '0;
      wb_we   <= 1'b0;
    end else begin
      wb_v    <= mem_v;
      wb_rd   <= mem_rd;
      wb_we   <= mem_we;
      mem_v   <= ex_v;
      mem_rd  <= ex_rd;
      mem_we  <= ex_we;
      mem_ld  <= ex_ld;
      ex_v    <= id_valid & ~flush & ~stall;
      ex_rs1  <= id_rs1;
      ex_rs2  <= id_rs2;
      ex_use1 <= id_use1;
      ex_use2 <= id_use2;
      ex_rd   <= id_rd;
      ex_we   <= id_we;
      ex_ld   <= id_load;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Pipeline control block that produces the 2-bit select codes consumed by the 3-input forwarding multiplexers in front of the EX-stage ALU operands, plus the load-use stall and branch flush for the 5-stage core. It keeps its own shadow pipeline of register-usage metadata (EX, MEM, WB slots), so it needs only ID-stage decode fields and the EX-stage branch outcome. Stall and flush event counters are included for performance debug.

## Interface
- REG_AW, 5: register-index width
- CNT_W, 16: event-counter width
- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW  ID source register indices
- id_use1, id_use2  in  1  ID instruction reads rs1 / rs2
- id_rd  in  REG_AW  ID destination index
- id_we  in  1  ID instruction writes rd
- id_load  in  1  ID instruction is a load
- br_taken  in  1  EX-stage branch/jump redirect this cycle
- stall  out  1  hold PC and IF/ID, bubble into EX
- flush  out  1  squash IF/ID and ID/EX contents
- fwd_a, fwd_b  out  2  EX operand select: 00 = register-file value, 01 = MEM/WB result, 10 = EX/MEM ALU result; 11 never driven
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Internal slots, updated every rising edge (no enable): EX{v, rs1, rs2, use1, use2, rd, we, ld}, MEM{v, rd, we, ld}, WB{v, rd, we}.
- Shift: WB <= MEM; MEM <= EX fields; EX <= ID fields with v = id_valid, except EX.v <= 0 when flush or stall.
- Writes qualify only when slot.v & we & rd != 0. Register x0 never matches.
- stall (combinational) = !br_taken & id_valid & EX.v & EX.ld & EX.we & EX.rd != 0 & ((id_use1 & id_rs1 == EX.rd) | (id_use2 & id_rs2 == EX.rd)).
- flush (combinational) = br_taken. Flush wins over stall. The branch in EX still advances to MEM.
- fwd_a (combinational from slots):
  - 10 if EX.v & EX.use1 & qualifying MEM write & !MEM.ld & MEM.rd == EX.rs1
  - else 01 if EX.v & EX.use1 & qualifying WB write & WB.rd == EX.rs1
  - else 00
- fwd_b: same rules using rs2/use2.
- MEM has priority over WB (youngest producer wins).
- Invariant: the stall guarantees a load in MEM never matches the EX consumer. The !MEM.ld term prevents ever selecting a load address as data.
- Writes three or more stages back are covered by the write-first register file, not by this unit.
- Counters: +1 on each cycle stall = 1 (respectively flush = 1). Hold at all-ones.

## Timing
- Reset (async assert, sync-to-clk deassert upstream): all slot v = 0, stall = 0, flush = 0, fwd_a = fwd_b = 00, counters 0. These take effect immediately on rstn low.
- stall and flush are same-cycle combinational outputs of the current ID/EX state. Pipeline registers elsewhere sample them on the same edge as the slots.
- A load-use pair costs exactly 1 stall cycle. The next cycle the load is in MEM, stall = 0, and the consumer gets fwd = 01 one cycle later in EX.
- fwd codes are valid in the same cycle the consumer occupies EX (zero-cycle latency from slot state).
- Simultaneous br_taken and load-use: stall = 0, flush = 1. EX receives a bubble, and only flush_cnt increments.
- Reset mid-operation discards all slot contents. No forwarding occurs on the first post-reset instructions.

## Test plan
- ALU back-to-back: add x5 issued, then sub reading x5 as rs1 next cycle -> when sub is in EX, fwd_a = 10, fwd_b = 00, stall never asserted.
- Distance-2: producer x7, one independent instruction, consumer reading x7 as rs2 -> fwd_b = 01 for exactly the consumer's EX cycle.
- Load-use: lw x3 then add reading x3 -> stall = 1 for exactly 1 cycle, stall_cnt 0 -> 1, EX bubble follows, then consumer in EX with fwd_a = 01.
- x0 and non-writers: producer rd = 0 or we = 0 feeding a matching consumer -> fwd = 00 and stall = 0 throughout.
- Double hit: MEM and WB both write x9, consumer reads x9 -> fwd_a = 10 (MEM priority).
- Flush vs stall plus reset: load-use pattern with br_taken = 1 in the same cycle -> stall = 0, flush = 1, flush_cnt +1. Then assert rstn = 0 mid-stream -> all outputs and counters 0 immediately, and the first consumer after release sees fwd = 00.
